// File: rtl/duck_pkg.sv
// duck_pkg: shared types and constants for the duck sprite engine.
//   duck_state_t : 2-bit FSM encoding, also driven out on duck_state.
//   SPRITE_W     : sprite edge length in pixels.
//   FSEL_*       : animation frame selects (upper ROM address bits).
//   PALETTE      : 16 x 24-bit {R,G,B}; index 0 is transparent.
//   sprite_pixel : ROM contents, addr = {frame_sel[1:0], row[4:0], col[4:0]}.
package duck_pkg;

  typedef enum logic [1:0] {
    DUCK_GONE = 2'd0,
    DUCK_FLY  = 2'd1,
    DUCK_HIT  = 2'd2,
    DUCK_FALL = 2'd3
  } duck_state_t;

  localparam int SPRITE_W = 32;

  localparam logic [1:0] FSEL_FLAP_UP = 2'd0;
  localparam logic [1:0] FSEL_FLAP_DN = 2'd1;
  localparam logic [1:0] FSEL_HIT     = 2'd2;
  localparam logic [1:0] FSEL_FALL    = 2'd3;

  typedef logic [23:0] palette_t [16];

  localparam palette_t PALETTE = '{
    24'h000000, 24'h1A1A1A, 24'h0B6623, 24'hFFFFFF,
    24'hFF8C00, 24'h8B5A2B, 24'h5C3A1E, 24'hD02020,
    24'h203080, 24'h40A0E0, 24'hE0E040, 24'h808080,
    24'hC0C0C0, 24'h604020, 24'h00FF00, 24'hFF00FF
  };

  // Sprite artwork described as painted rectangles (later ones win).
  // Frames 2/3 recolour the body red; frame 3 is frame 2 upside down.
  function automatic logic [3:0] sprite_pixel(input logic [11:0] addr);
    logic [1:0] f;
    logic [4:0] r;
    logic [4:0] c;
    logic [3:0] body;
    logic [3:0] px;
    f    = addr[11:10];
    r    = (addr[11:10] == FSEL_FALL) ? (5'd31 - addr[9:5]) : addr[9:5];
    c    = addr[4:0];
    body = f[1] ? 4'd7 : 4'd5;
    px   = 4'd0;
    if (r >= 5'd12 && r <= 5'd23 && c >= 5'd2 && c <= 5'd25) px = body;
    if (r >= 5'd4 && r <= 5'd11 && c >= 5'd2 && c <= 5'd7)   px = body;
    if (r >= 5'd4 && r <= 5'd11 && c >= 5'd20 && c <= 5'd27) px = 4'd2;
    if (r >= 5'd8 && r <= 5'd9 && c >= 5'd28)                px = 4'd4;
    if (r == 5'd6 && c == 5'd24)                             px = 4'd3;
    if (r >= 5'd24 && r <= 5'd27 && (c == 5'd10 || c == 5'd18)) px = 4'd4;
    if (f == FSEL_FLAP_UP && r >= 5'd6 && r <= 5'd11 && c >= 5'd8 && c <= 5'd15)
      px = 4'd6;
    if (f != FSEL_FLAP_UP && r >= 5'd18 && r <= 5'd25 && c >= 5'd8 && c <= 5'd15)
      px = 4'd6;
    return px;
  endfunction

endpackage

// File: rtl/duck_sprite_rom.sv
// duck_sprite_rom: 4096 x 4 synchronous palette-index ROM.
//   clk   in  1   clock
//   rst_n in  1   async active-low reset (clears the address register)
//   addr  in  12  {frame_sel, row, col}
//   data  out 4   palette index for the address presented one cycle earlier
module duck_sprite_rom
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  output logic [3:0]  data
);

  logic [11:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= 12'd0;
    else        addr_q <= addr;
  end

  assign data = sprite_pixel(addr_q);

endmodule

// File: rtl/duck_sprite.sv
// duck_sprite: duck motion/animation FSM plus 2-stage per-pixel renderer.
//   Clk        in  1   pixel clock
//   Reset_n    in  1   async active-low reset
//   frame_clk  in  1   vsync level (sync to Clk); rising edge = frame tick
//   DrawX/Y    in  10  current pixel coordinates
//   spawn      in  1   pulse: launch a duck (only honoured in GONE)
//   shot       in  1   pulse: duck hit (only honoured in FLY)
//   is_duck    out 1   opaque duck pixel for coordinates of 2 cycles earlier
//   duck_color out 24  colour of that pixel, 0 when transparent
//   duck_state out 2   current FSM state (duck_state_t)
// Handshake: none; spawn/shot are single-cycle strobes sampled every Clk,
// and the pixel path accepts one coordinate per cycle with fixed latency 2.
module duck_sprite
  import duck_pkg::*;
#(
  parameter logic [9:0]        SPAWN_X    = 10'd64,
  parameter logic [9:0]        SPAWN_Y    = 10'd300,
  parameter logic signed [3:0] VX_INIT    = 4'sd2,
  parameter logic signed [3:0] VY_INIT    = -4'sd1,
  parameter logic [9:0]        X_MAX      = 10'd608,
  parameter logic [9:0]        Y_MAX      = 10'd352,
  parameter logic [9:0]        GROUND_Y   = 10'd416,
  parameter logic [9:0]        FALL_SPEED = 10'd4,
  parameter logic [5:0]        HIT_FRAMES = 6'd30,
  parameter logic [3:0]        FLAP_DIV   = 4'd8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        spawn,
  input  logic        shot,
  output logic        is_duck,
  output logic [23:0] duck_color,
  output logic [1:0]  duck_state
);

  duck_state_t       state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [3:0] vx_q, vx_d, vy_q, vy_d;
  logic              flap_q, flap_d;
  logic [3:0]        flap_cnt_q, flap_cnt_d;
  logic [5:0]        hit_cnt_q, hit_cnt_d;
  logic              frame_prev_q;
  logic              tick;

  logic signed [10:0] nx, ny;
  logic [10:0]        y_fall;

  assign tick   = frame_clk & ~frame_prev_q;
  assign nx     = $signed({1'b0, x_q}) + $signed({{7{vx_q[3]}}, vx_q});
  assign ny     = $signed({1'b0, y_q}) + $signed({{7{vy_q[3]}}, vy_q});
  assign y_fall = {1'b0, y_q} + {1'b0, FALL_SPEED};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    flap_d     = flap_q;
    flap_cnt_d = flap_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    case (state_q)
      DUCK_GONE: begin
        if (spawn) begin
          // A fresh duck starts its animation from the beginning.
          state_d    = DUCK_FLY;
          x_d        = SPAWN_X;
          y_d        = SPAWN_Y;
          vx_d       = VX_INIT;
          vy_d       = VY_INIT;
          flap_d     = 1'b0;
          flap_cnt_d = 4'd0;
          hit_cnt_d  = 6'd0;
        end
      end
      DUCK_FLY: begin
        if (shot) begin
          // Shot wins over a coincident tick: the duck freezes where it is.
          state_d   = DUCK_HIT;
          hit_cnt_d = 6'd0;
        end else if (tick) begin
          if (nx < 11'sd0) begin
            x_d  = 10'd0;
            vx_d = -vx_q;
          end else if (nx > $signed({1'b0, X_MAX})) begin
            x_d  = X_MAX;
            vx_d = -vx_q;
          end else begin
            x_d = nx[9:0];
          end
          if (ny < 11'sd0) begin
            y_d  = 10'd0;
            vy_d = -vy_q;
          end else if (ny > $signed({1'b0, Y_MAX})) begin
            y_d  = Y_MAX;
            vy_d = -vy_q;
          end else begin
            y_d = ny[9:0];
          end
          if (flap_cnt_q == FLAP_DIV - 4'd1) begin
            flap_cnt_d = 4'd0;
            flap_d     = ~flap_q;
          end else begin
            flap_cnt_d = flap_cnt_q + 4'd1;
          end
        end
      end
      DUCK_HIT: begin
        if (tick) begin
          if (hit_cnt_q == HIT_FRAMES - 6'd1) state_d = DUCK_FALL;
          else                                hit_cnt_d = hit_cnt_q + 6'd1;
        end
      end
      DUCK_FALL: begin
        if (tick) begin
          // y is allowed to pass GROUND_Y; the duck is invisible once GONE.
          y_d = y_fall[9:0];
          if (y_fall >= {1'b0, GROUND_Y}) state_d = DUCK_GONE;
        end
      end
      default: state_d = DUCK_GONE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= DUCK_GONE;
      x_q          <= SPAWN_X;
      y_q          <= SPAWN_Y;
      vx_q         <= VX_INIT;
      vy_q         <= VY_INIT;
      flap_q       <= 1'b0;
      flap_cnt_q   <= 4'd0;
      hit_cnt_q    <= 6'd0;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      flap_q       <= flap_d;
      flap_cnt_q   <= flap_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_prev_q <= frame_clk;
    end
  end

  assign duck_state = state_q;

  // ---------------- pixel pipeline ----------------
  // C0: box test and ROM address. Only the low 5 bits of the offsets are
  // needed, and those equal the difference of the low 5 bits.
  logic [10:0] x_end, y_end;
  logic        inbox_c;
  logic [4:0]  col_c, row_c;
  logic [1:0]  frame_sel;
  logic [11:0] rom_addr;
  logic [3:0]  idx;

  assign x_end = {1'b0, x_q} + 11'd32;
  assign y_end = {1'b0, y_q} + 11'd32;

  always_comb begin
    inbox_c = ({1'b0, DrawX} >= {1'b0, x_q}) && ({1'b0, DrawX} < x_end) &&
              ({1'b0, DrawY} >= {1'b0, y_q}) && ({1'b0, DrawY} < y_end);
    row_c   = DrawY[4:0] - y_q[4:0];
    col_c   = DrawX[4:0] - x_q[4:0];
    // Face the direction of travel while flying.
    if (state_q == DUCK_FLY && vx_q[3]) col_c = 5'd31 - col_c;
    case (state_q)
      DUCK_FLY:  frame_sel = flap_q ? FSEL_FLAP_DN : FSEL_FLAP_UP;
      DUCK_HIT:  frame_sel = FSEL_HIT;
      DUCK_FALL: frame_sel = FSEL_FALL;
      default:   frame_sel = FSEL_FLAP_UP;
    endcase
    rom_addr = {frame_sel, row_c, col_c};
  end

  duck_sprite_rom u_rom (
    .clk   (Clk),
    .rst_n (Reset_n),
    .addr  (rom_addr),
    .data  (idx)
  );

  // C1: flags travel alongside the ROM read.
  logic        inbox_q;
  duck_state_t state_p1_q;
  // C2: registered outputs.
  logic        is_duck_q, is_duck_d;
  logic [23:0] duck_color_q, duck_color_d;

  always_comb begin
    is_duck_d    = inbox_q && (idx != 4'd0) && (state_p1_q != DUCK_GONE);
    duck_color_d = is_duck_d ? PALETTE[idx] : 24'h0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inbox_q      <= 1'b0;
      state_p1_q   <= DUCK_GONE;
      is_duck_q    <= 1'b0;
      duck_color_q <= 24'h0;
    end else begin
      inbox_q      <= inbox_c;
      state_p1_q   <= state_q;
      is_duck_q    <= is_duck_d;
      duck_color_q <= duck_color_d;
    end
  end

  assign is_duck    = is_duck_q;
  assign duck_color = duck_color_q;

endmodule

// File: tb/tb_duck_sprite.sv
// tb_duck_sprite: random-pixel bench for duck_sprite with a behavioural model
// of the duck (position, velocity, tick counts) and an expected-output queue.
module tb_duck_sprite;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_clk, spawn, shot;
  logic [9:0]  draw_x, draw_y;
  logic        is_duck;
  logic [23:0] duck_color;
  logic [1:0]  duck_state;

  always #5 clk = ~clk;

  duck_sprite dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .frame_clk  (frame_clk),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .spawn      (spawn),
    .shot       (shot),
    .is_duck    (is_duck),
    .duck_color (duck_color),
    .duck_state (duck_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // States as plain numbers: 0 gone, 1 flying, 2 hit, 3 falling.
  int m_state, m_x, m_y, m_vx, m_vy, m_frames, m_hits;
  bit m_prev;

  logic [23:0] pal [16] = '{
    24'h000000, 24'h1A1A1A, 24'h0B6623, 24'hFFFFFF,
    24'hFF8C00, 24'h8B5A2B, 24'h5C3A1E, 24'hD02020,
    24'h203080, 24'h40A0E0, 24'hE0E040, 24'h808080,
    24'hC0C0C0, 24'h604020, 24'h00FF00, 24'hFF00FF
  };

  // Artwork: rectangles painted in order; fmask bit n = used in frame n.
  typedef struct { int fmask; int r0; int r1; int c0; int c1; int idx; } rect_t;
  rect_t rects [11] = '{
    '{3, 12, 23, 2, 25, 5},  '{12, 12, 23, 2, 25, 7},
    '{3, 4, 11, 2, 7, 5},    '{12, 4, 11, 2, 7, 7},
    '{15, 4, 11, 20, 27, 2}, '{15, 8, 9, 28, 31, 4},
    '{15, 6, 6, 24, 24, 3},  '{15, 24, 27, 10, 10, 4},
    '{15, 24, 27, 18, 18, 4},'{1, 6, 11, 8, 15, 6},
    '{14, 18, 25, 8, 15, 6}
  };

  function automatic int art(int frame, int row, int col);
    int r = (frame == 3) ? 31 - row : row;
    int px = 0;
    foreach (rects[i])
      if (((rects[i].fmask >> frame) & 1) != 0 && r >= rects[i].r0 && r <= rects[i].r1 &&
          col >= rects[i].c0 && col <= rects[i].c1)
        px = rects[i].idx;
    return px;
  endfunction

  function automatic logic [24:0] model_pixel(int dx, int dy);
    int col, row, frame, idx;
    if (m_state == 0) return 25'h0;
    if (!(dx >= m_x && dx < m_x + 32 && dy >= m_y && dy < m_y + 32)) return 25'h0;
    col = dx - m_x;
    row = dy - m_y;
    if (m_state == 1 && m_vx < 0) col = 31 - col;
    frame = (m_state == 1) ? (m_frames / 8) % 2 : m_state;
    idx = art(frame, row, col);
    if (idx == 0) return 25'h0;
    return {1'b1, pal[idx]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 64; m_y = 300; m_vx = 2; m_vy = -1;
    m_frames = 0; m_hits = 0; m_prev = 0;
    exp_q.delete();
    exp_q.push_back(25'h0);
  endtask

  task automatic model_clock(bit fc, bit sp, bit sh);
    bit tk = fc && !m_prev;
    int n;
    m_prev = fc;
    case (m_state)
      0: if (sp) begin
        m_state = 1; m_x = 64; m_y = 300; m_vx = 2; m_vy = -1; m_frames = 0;
      end
      1: if (sh) begin
        m_state = 2; m_hits = 0;
      end else if (tk) begin
        n = m_x + m_vx;
        if (n < 0 || n > 608) begin m_x = (n < 0) ? 0 : 608; m_vx = -m_vx; end
        else m_x = n;
        n = m_y + m_vy;
        if (n < 0 || n > 352) begin m_y = (n < 0) ? 0 : 352; m_vy = -m_vy; end
        else m_y = n;
        m_frames++;
      end
      2: if (tk) begin
        m_hits++;
        if (m_hits == 30) m_state = 3;
      end
      default: if (tk) begin
        m_y += 4;
        if (m_y >= 416) m_state = 0;
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step(bit fc, bit sp, bit sh, logic [9:0] dx, logic [9:0] dy);
    frame_clk = fc; spawn = sp; shot = sh; draw_x = dx; draw_y = dy;
    exp_q.push_back(model_pixel(int'(dx), int'(dy)));
    model_clock(fc, sp, sh);
    @(posedge clk); #1;
    check("pixel", {7'd0, is_duck, duck_color}, {7'd0, exp_q.pop_front()});
    check("state", {30'd0, duck_state}, m_state);
  endtask

  function automatic logic [9:0] near(int base);
    return 10'((base + int'($urandom_range(0, 44)) - 6) & 1023);
  endfunction

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Each frame: vsync high 1 cycle, low 2 cycles.
  task automatic run_ticks(int n, int spawn_pct, int shot_pct);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 3; c++)
        step(c == 0, pct(spawn_pct), pct(shot_pct), near(m_x), near(m_y));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; frame_clk = 0; spawn = 0; shot = 0; draw_x = 0; draw_y = 0;
    #1;
    check("reset_is_duck", {31'd0, is_duck}, 0);
    check("reset_color", {8'd0, duck_color}, 0);
    check("reset_state", {30'd0, duck_state}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // No duck yet: everything stays dark across frames.
    run_ticks(50, 0, 30);

    // Spawn, then probe an opaque pixel, a pixel left of the box, a transparent corner.
    step(0, 1, 0, 10'd69, 10'd305);
    step(0, 0, 0, 10'd69, 10'd305);
    step(0, 0, 0, 10'd63, 10'd305);
    step(0, 0, 0, 10'd64, 10'd300);
    step(0, 0, 0, 10'd74, 10'd315);
    step(0, 0, 0, 10'd74, 10'd315);

    // Long flight: right wall bounce near tick 272, top bounce at tick 300.
    run_ticks(320, 10, 0);

    // Shot coincident with a tick, then the hit hold and the fall to ground.
    step(1, 0, 1, near(m_x), near(m_y));
    step(0, 0, 0, near(m_x), near(m_y));
    step(0, 0, 0, near(m_x), near(m_y));
    run_ticks(30, 10, 20);
    check("fall_after_hit", {30'd0, duck_state}, 3);
    run_ticks(110, 0, 20);
    check("gone_after_fall", {30'd0, duck_state}, 0);

    // Shots while gone do nothing; a new spawn flies from the spawn point.
    run_ticks(10, 0, 30);
    step(0, 1, 0, 10'd69, 10'd305);
    run_ticks(40, 0, 0);
    step(0, 0, 1, near(m_x), near(m_y));
    run_ticks(35, 0, 0);

    // Reset during FALL clears outputs immediately and blocks motion.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_is_duck", {31'd0, is_duck}, 0);
    check("midreset_color", {8'd0, duck_color}, 0);
    check("midreset_state", {30'd0, duck_state}, 0);
    for (int i = 0; i < 4; i++) begin
      frame_clk = i[0];
      draw_x = near(64); draw_y = near(300);
      @(posedge clk); #1;
      check("held_is_duck", {31'd0, is_duck}, 0);
      check("held_state", {30'd0, duck_state}, 0);
    end
    frame_clk = 0;
    rst_n = 1'b1;
    model_reset();
    run_ticks(20, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
